// File: rtl/bram_fill_ctrl_pkg.sv
// Shared types for the BRAM fill controller: FSM states and fill modes.
package bram_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_INCR   = 2'd1,
    MODE_STREAM = 2'd2
  } mode_e;

  // Raw mode pins to a fill mode; the reserved code behaves as CONST.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_INCR;
      2'd2:    return MODE_STREAM;
      default: return MODE_CONST;
    endcase
  endfunction

endpackage

// File: rtl/bram_fill_ctrl_if.sv
// Stream word channel feeding STREAM-mode fills.
interface bram_fill_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bram.sv
// Simple dual-port RAM: port A write, port B registered read-first read.
module bram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 43328,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [ADDR_W-1:0]     addr_b,
  output logic [DATA_WIDTH-1:0] dout_b
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port A write; array contents are deliberately never reset.
  always_ff @(posedge clk)
    if (we_a) mem[addr_a] <= din_a;

  // Port B read samples the pre-write word, so a colliding read sees old data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout_b <= '0;
    else        dout_b <= mem[addr_b];
endmodule

// File: rtl/bram_fill_ctrl.sv
// Fill engine owning a feature BRAM: CONST / INCR / STREAM fills on port A,
// host byte-addressed reads on port B.
module bram_fill_ctrl
  import bram_fill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 43328,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      length,
  input  logic [DATA_WIDTH-1:0] init_value,
  bram_fill_ctrl_if.slave       strm,
  input  logic [ADDR_W+1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  filled,
  output logic [CNT_W-1:0]      wr_count
);
  state_e                state;
  mode_e                 mode_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] init_q;
  logic                  s_ready_q;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_W-1:0]     base_wrap;
  logic [ADDR_W-1:0]     addr_next;
  logic                  unused_rd_lsb;

  assign strm.s_ready  = s_ready_q;
  assign unused_rd_lsb = ^rd_addr[1:0];

  // Base may exceed DEPTH-1 when DEPTH is not a power of two; one subtract folds it.
  assign base_wrap = (int'(base_addr) >= DEPTH) ? ADDR_W'(int'(base_addr) - DEPTH) : base_addr;
  assign addr_next = (addr_q == ADDR_W'(DEPTH-1)) ? '0 : addr_q + ADDR_W'(1);

  // A write happens on every FILL cycle except aborts and idle stream cycles.
  assign wr_fire = (state == ST_FILL) && !abort &&
                   ((mode_q != MODE_STREAM) || (strm.s_valid && s_ready_q));

  // Select the word written this cycle from the latched mode.
  always_comb begin
    wr_data = init_q;
    case (mode_q)
      MODE_INCR:   wr_data = init_q + DATA_WIDTH'(wr_count);
      MODE_STREAM: wr_data = strm.s_data;
      default:     wr_data = init_q;
    endcase
  end

  // Fill sequencer with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_CONST;
      addr_q    <= '0;
      len_q     <= '0;
      init_q    <= '0;
      wr_count  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      filled    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          mode_q   <= decode_mode(mode);
          addr_q   <= base_wrap;
          len_q    <= length;
          init_q   <= init_value;
          wr_count <= '0;
          filled   <= 1'b0;
          if (length == '0) begin
            state <= ST_DONE;
          end else begin
            state     <= ST_FILL;
            busy      <= 1'b1;
            s_ready_q <= (decode_mode(mode) == MODE_STREAM);
          end
        end
        ST_FILL: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            s_ready_q <= 1'b0;
          end else if (wr_fire) begin
            wr_count <= wr_count + CNT_W'(1);
            addr_q   <= addr_next;
            if (wr_count + CNT_W'(1) == len_q) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              s_ready_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          done   <= 1'b1;
          filled <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .rst_n (rst_n),
    .we_a  (wr_fire),
    .addr_a(addr_q),
    .din_a (wr_data),
    .addr_b(rd_addr[ADDR_W+1:2]),
    .dout_b(rd_data)
  );
endmodule
